// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to
// icache and buffers returned words with their PCs for decode.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    output logic [XLEN-1:0] req_address,
    output logic            req_operation,
    input  logic            req_fulfilled,
    input  logic [31:0]     req_loaded_word,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic OP_READ = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] redirect_tgt;

    logic [31:0]     word_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     hold_instr_q;
    logic [XLEN-1:0] hold_pc_q;

    logic push;
    logic pop;
    logic flush;
    logic issue;
    logic has_space;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign has_space    = count_q < CW'(FIFO_DEPTH);
    assign flush        = redirect_valid;
    assign instr_valid  = count_q != '0;
    assign pop          = instr_valid & instr_ready;

    assign req_valid     = state_q != IDLE;
    assign req_address   = req_addr_q;
    assign req_operation = OP_READ;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        issue      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end else if (has_space) begin
                    state_d = REQ;
                    issue   = 1'b1;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = req_fulfilled ? IDLE : DISCARD;
                end else if (req_fulfilled) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = IDLE;
                end
            end
            DISCARD: begin
                // The stale read must still complete; its word is thrown away.
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (req_fulfilled) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (issue) begin
                req_addr_q <= fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= req_loaded_word;
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    // Remember the head so the outputs stay put once the buffer drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else if (instr_valid) begin
            hold_instr_q <= word_mem[rd_ptr_q];
            hold_pc_q    <= pc_mem[rd_ptr_q];
        end
    end

    assign instr    = instr_valid ? word_mem[rd_ptr_q] : hold_instr_q;
    assign instr_pc = instr_valid ? pc_mem[rd_ptr_q]   : hold_pc_q;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised-data bench for fetch_unit with a queue-based reference model
// and a simple icache responder of programmable latency.
module tb_fetch_unit;

    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_address;
    logic        req_operation;
    logic        req_fulfilled;
    logic [31:0] req_loaded_word;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        req_valid2;
    logic [31:0] req_address2;
    logic        req_operation2;
    logic        req_fulfilled2;
    logic [31:0] req_loaded_word2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;

    int errors;
    int checks;

    int          lat;
    int          cur_lat;
    int          waited;
    bit          busy;
    bit          tainted;
    logic [31:0] cur_addr;
    logic [31:0] next_pc;
    ent_t        exp_q[$];
    ent_t        pop_log[$];
    logic [31:0] req_log[$];

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_address(req_address),
        .req_operation(req_operation), .req_fulfilled(req_fulfilled),
        .req_loaded_word(req_loaded_word),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_address(req_address2),
        .req_operation(req_operation2), .req_fulfilled(req_fulfilled2),
        .req_loaded_word(req_loaded_word2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2),
        .instr(instr2), .instr_pc(instr_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA0 + {2'b00, a[31:2]};
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        req_fulfilled  = 1'b0;
        busy           = 1'b0;
        tainted        = 1'b0;
        lat            = 1;
        next_pc        = 32'h0;
        exp_q.delete();
        pop_log.delete();
        req_log.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: icache responder, then reference-model update at the edge.
    task automatic tick();
        bit          f;
        bit          p;
        bit          r;
        logic [31:0] opc;
        logic [31:0] ow;
        ent_t        e;
        checks++;
        if (instr_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL instr_valid: got %b want %b",
                     instr_valid, exp_q.size() != 0);
        end
        req_fulfilled   = 1'b0;
        req_loaded_word = $urandom;
        if (req_valid === 1'b1) begin
            if (!busy) begin
                busy    = 1'b1;
                waited  = 0;
                cur_lat = lat;
                cur_addr = req_address;
                req_log.push_back(req_address);
                checks++;
                if (req_address !== next_pc) begin
                    errors++;
                    $display("FAIL req_start_addr: got %h want %h",
                             req_address, next_pc);
                end
                checks++;
                if (exp_q.size() >= FIFO_DEPTH) begin
                    errors++;
                    $display("FAIL req_space: issued with %0d buffered",
                             exp_q.size());
                end
                checks++;
                if (req_operation !== 1'b0) begin
                    errors++;
                    $display("FAIL req_op: got %b want 0", req_operation);
                end
            end else begin
                checks++;
                if (req_address !== cur_addr) begin
                    errors++;
                    $display("FAIL req_hold: got %h want %h",
                             req_address, cur_addr);
                end
            end
            waited++;
            if (waited >= cur_lat) begin
                req_fulfilled   = 1'b1;
                req_loaded_word = word_of(cur_addr);
            end
        end else if (busy) begin
            checks++;
            errors++;
            $display("FAIL req_dropped: req_valid=%b while %h pending",
                     req_valid, cur_addr);
        end
        f   = req_fulfilled;
        p   = (instr_valid === 1'b1) && instr_ready;
        r   = redirect_valid;
        opc = instr_pc;
        ow  = instr;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            next_pc = redirect_pc & ~32'h3;
            if (busy && !f) tainted = 1'b1;
        end else begin
            if (p) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty: popped %h/%h, model empty", opc, ow);
                end else begin
                    e = exp_q.pop_front();
                    if (opc !== e.pc || ow !== e.word) begin
                        errors++;
                        $display("FAIL pop_data: got %h/%h want %h/%h",
                                 opc, ow, e.pc, e.word);
                    end
                    pop_log.push_back('{opc, ow});
                end
            end
            if (f && !tainted) begin
                exp_q.push_back('{cur_addr, word_of(cur_addr)});
                next_pc = cur_addr + 32'd4;
            end
        end
        if (f) begin
            busy    = 1'b0;
            tainted = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: req_valid=%b instr_valid=%b want 0 0",
                     req_valid, instr_valid);
        end
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_head: instr=%h pc=%h want 0 0", instr, instr_pc);
        end
        checks++;
        if (req_valid2 !== 1'b0 || instr_valid2 !== 1'b0 || instr2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_wrap_inst: req=%b iv=%b instr=%h want 0 0 0",
                     req_valid2, instr_valid2, instr2);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 30 && pop_log.size() < 3; k++) tick();
        checks++;
        if (pop_log.size() < 3) begin
            errors++;
            $display("FAIL seq_timeout: got %0d pops want 3", pop_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < pop_log.size()) begin
                checks++;
                if (pop_log[i].pc !== 32'(i * 4) || pop_log[i].word !== 32'(32'hA0 + i)) begin
                    errors++;
                    $display("FAIL seq_instr%0d: got %h/%h want %h/%h", i,
                             pop_log[i].pc, pop_log[i].word, i * 4, 32'hA0 + i);
                end
                checks++;
                if (req_log[i] !== 32'(i * 4)) begin
                    errors++;
                    $display("FAIL seq_req%0d: got %h want %h", i, req_log[i], i * 4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (20) tick();
        checks++;
        if (req_log.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d requests want 4", req_log.size());
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL bp_addr%0d: got %h want %h", i, req_log[i], i * 4);
            end
        end
        checks++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_full: req=%b iv=%b pc=%h want 0 1 0",
                     req_valid, instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 6 && req_log.size() < 5; k++) tick();
        checks++;
        if (req_log.size() != 5 || req_log[req_log.size() - 1] !== 32'h10) begin
            errors++;
            $display("FAIL bp_resume: got %0d requests last %h want 5 last 10",
                     req_log.size(), req_log[req_log.size() - 1]);
        end
    endtask

    task automatic test_hold();
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 20 && pop_log.size() < 2; k++) tick();
        lat = 1000;
        repeat (8) tick();
        checks++;
        if (pop_log.size() < 2) begin
            errors++;
            $display("FAIL hold_timeout: got %0d pops want >=2", pop_log.size());
        end else if (instr_valid !== 1'b0 ||
                     instr !== pop_log[pop_log.size() - 1].word ||
                     instr_pc !== pop_log[pop_log.size() - 1].pc) begin
            errors++;
            $display("FAIL hold_head: got %b %h/%h want 0 %h/%h",
                     instr_valid, instr_pc, instr,
                     pop_log[pop_log.size() - 1].pc,
                     pop_log[pop_log.size() - 1].word);
        end
    endtask

    task automatic test_redirect_miss();
        bit seen8;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 20 && req_log.size() < 2; k++) tick();
        lat = 3;
        for (int k = 0; k < 20 && req_log.size() < 3; k++) tick();
        checks++;
        if (req_log.size() != 3 || req_address !== 32'h8 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL miss_setup: n=%0d addr=%h valid=%b want 3 8 1",
                     req_log.size(), req_address, req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 10 && busy; k++) tick();
        checks++;
        if (busy || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_drain: busy=%b iv=%b want 0 0", busy, instr_valid);
        end
        for (int k = 0; k < 10 && req_log.size() < 4; k++) tick();
        checks++;
        if (req_log.size() != 4 || req_log[3] !== 32'h200) begin
            errors++;
            $display("FAIL miss_next: n=%0d addr=%h want 4 200",
                     req_log.size(), req_log[req_log.size() - 1]);
        end
        for (int k = 0; k < 10 && pop_log.size() < 3; k++) tick();
        seen8 = 1'b0;
        foreach (pop_log[i]) if (pop_log[i].pc === 32'h8) seen8 = 1'b1;
        checks++;
        if (seen8 || pop_log.size() < 3 || pop_log[2].word !== 32'h120) begin
            errors++;
            $display("FAIL miss_stream: seen8=%b n=%0d word=%h want 0 3 120",
                     seen8, pop_log.size(), pop_log[pop_log.size() - 1].word);
        end
    endtask

    task automatic test_redirect_fulfill();
        do_reset();
        for (int k = 0; k < 20 && req_log.size() < 1; k++) tick();
        lat = 2;
        for (int k = 0; k < 20 && req_log.size() < 2; k++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || req_address !== 32'h4) begin
            errors++;
            $display("FAIL rf_setup: iv=%b pc=%h addr=%h want 1 0 4",
                     instr_valid, instr_pc, req_address);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        lat = 1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rf_flush: iv=%b want 0", instr_valid);
        end
        for (int k = 0; k < 10 && req_log.size() < 3; k++) tick();
        checks++;
        if (req_log.size() != 3 || req_log[2] !== 32'h100) begin
            errors++;
            $display("FAIL rf_next: n=%0d addr=%h want 3 100",
                     req_log.size(), req_log[req_log.size() - 1]);
        end
        for (int k = 0; k < 10 && pop_log.size() < 1; k++) tick();
        checks++;
        if (pop_log.size() < 1 || pop_log[0].pc !== 32'h100) begin
            errors++;
            $display("FAIL rf_first_pop: n=%0d pc=%h want >=1 100",
                     pop_log.size(), pop_log.size() > 0 ? pop_log[0].pc : 32'hx);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFA;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 30 && req_log.size() < 4; k++) tick();
        checks++;
        if (req_log.size() < 4 || req_log[1] !== 32'hFFFF_FFF8 ||
            req_log[2] !== 32'hFFFF_FFFC || req_log[3] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_redirect: n=%0d want FFFFFFF8 FFFFFFFC 0",
                     req_log.size());
        end
    endtask

    task automatic test_reset_pc();
        logic [31:0] seen[$];
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (req_valid2 === 1'b1) begin
                seen.push_back(req_address2);
                checks++;
                if (req_operation2 !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_op: got %b want 0", req_operation2);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen.size() < 3 || seen[0] !== 32'hFFFF_FFF8 ||
            seen[1] !== 32'hFFFF_FFFC || seen[2] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_reset_pc: n=%0d first=%h want FFFFFFF8 FFFFFFFC 0",
                     seen.size(), seen.size() > 0 ? seen[0] : 32'hx);
        end
        checks++;
        if (instr_valid2 !== 1'b1 && instr_pc2 === 32'h0 && instr2 === 32'h0) begin
            errors++;
            $display("FAIL wrap_stream: iv=%b pc=%h instr=%h want activity",
                     instr_valid2, instr_pc2, instr2);
        end
    endtask

    task automatic test_reset_discard();
        do_reset();
        for (int k = 0; k < 20 && exp_q.size() < 2; k++) tick();
        lat = 8;
        for (int k = 0; k < 10 && req_log.size() < 3; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_req_nonempty: req=%b iv=%b pc=%h want 0 0 0",
                     req_valid, instr_valid, instr_pc);
        end
        do_reset();
        lat = 8;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (req_valid !== 1'b1 || req_address !== 32'h0) begin
            errors++;
            $display("FAIL rst_discard_setup: req=%b addr=%h want 1 0",
                     req_valid, req_address);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard_async: req=%b iv=%b want 0 0",
                     req_valid, instr_valid);
        end
        do_reset();
        tick();
        checks++;
        if (req_log.size() != 1 || req_log[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_discard_restart: n=%0d addr=%h want 1 0",
                     req_log.size(), req_address);
        end
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        instr_ready      = 1'b0;
        req_fulfilled    = 1'b0;
        req_loaded_word  = '0;
        req_fulfilled2   = 1'b1;
        req_loaded_word2 = 32'h1234_5678;
        redirect_valid2  = 1'b0;
        redirect_pc2     = '0;
        instr_ready2     = 1'b1;
        lat              = 1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_hold();
        test_redirect_miss();
        test_redirect_fulfill();
        test_wrap();
        test_reset_pc();
        test_reset_discard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
